mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory arbiter that shares the single data memory between the `mips` core (port 0) and a debug/program-loader master (port 1). It sits between the requesters and `mem`, and drives the memory's address, write-data, `memwrite` and `readtype` inputs. It grants at most one access per cycle and returns read data to the winning port one cycle later. Arbitration is round-robin, with an optional bounded lock for burst program loading.

## Interface

Parameters:
- `N`, 64, data/address width
- `MAXLOCK`, 16, max consecutive locked grants while the other port waits (≥1)

Ports (`p` ∈ {0,1}; 0 = cpu, 1 = dbg):
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `req_p`  in  1  access request
- `lock_p`  in  1  request exclusive ownership after grant
- `we_p`  in  2  memwrite encoding, passed through; 2'b00 = read
- `rtype_p`  in  1  readtype, passed through
- `addr_p`  in  N  byte address
- `wdata_p`  in  N  write data
- `gnt_p`  out  1  combinational; access performed this cycle
- `rvalid_p`  out  1  registered; read data valid
- `rdata_p`  out  N  registered; last read data
- `m_memwrite`  out  2  to mem
- `m_readtype`  out  1  to mem
- `m_adr`  out  N  to mem
- `m_wdata`  out  N  to mem
- `m_rdata`  in  N  from mem, combinational read

## Operation

- Registered state: `st` ∈ {IDLE, LOCK0, LOCK1}, priority pointer `ptr`, lock counter `cnt` (width `$clog2(MAXLOCK+1)`), `rvalid_p`, `rdata_p`.
- Each cycle, `gnt_0` and `gnt_1` are one-hot or zero. The memory mux selects the granted port.
- With no grant: `m_memwrite`=00, `m_readtype`=0, `m_adr`=0, `m_wdata`=0.
- IDLE arbitration:
  - One requester: it is granted.
  - Both requesting: port `ptr` is granted.
  - After any grant to port p, `ptr` <= the other port.
- Lock entry: a grant to p in IDLE with `lock_p`=1 moves to LOCKp with `cnt`<=1.
- LOCKp:
  - `req_p`=1 and (`cnt`<`MAXLOCK` or `req_other`=0): grant p and increment `cnt`, saturating at `MAXLOCK`. Next state is LOCKp if `lock_p`=1, else IDLE (`cnt`<=0, `ptr`<=other).
  - `req_p`=1, `cnt`==`MAXLOCK`, `req_other`=1: forced release. Grant the other port; `st`<=IDLE, `cnt`<=0, `ptr`<=p.
  - `req_p`=0: this cycle arbitrates as IDLE (the other port may win, and may lock). State leaves LOCKp.
- The other port is never granted in LOCKp except by forced release.
- Read response: a granted cycle with `we_p`=00 sets `rvalid_p`<=1 and `rdata_p`<=`m_rdata` at the next edge.
- `rvalid_p` is a one-cycle pulse per read. `rdata_p` holds its value until the next read on that port.
- Writes produce no response; `gnt_p` is the write acknowledge.

## Timing

- Reset values: `st`=IDLE, `ptr`=0, `cnt`=0, `rvalid_p`=0, `rdata_p`=0. Outputs `gnt_p`=0 and mem outputs idle while `reset`=1.
- Asserting `reset` mid-burst clears state immediately; an in-flight read produces no `rvalid`.
- Grant latency is 0 cycles (same cycle as `req`). Read data latency is 1 cycle after grant.
- Requesters hold `addr`/`we`/`wdata` stable until `gnt`.
- Back-to-back reads on one port produce `rvalid` on consecutive cycles.
- Simultaneous `req` from both ports with `lock` on both: the `ptr` winner locks; the loser waits for release or forced release.

## Test plan

- Reset: hold `reset`=1 with `req_0`=`req_1`=1 -> `gnt`=00, `m_memwrite`=00, `rvalid`=0, `rdata`=0. After release, `gnt_0` is granted first.
- Single read: `req_0`=1, `we_0`=00, `addr_0`=0x40, `m_rdata`=0xDEAD_BEEF -> `gnt_0`=1 and `m_adr`=0x40 the same cycle. Next cycle `rvalid_0`=1 and `rdata_0`=0xDEAD_BEEF. The cycle after, `rvalid_0`=0.
- Fairness: both ports request reads continuously, no lock -> grants alternate 0,1,0,1. Each `rvalid` pulse follows its own grant by one cycle.
- Forced release, `MAXLOCK`=4: `req_1`/`lock_1`/`we_1`=01 held, `req_0`=1 -> `gnt_1` for 4 cycles, then `gnt_0` for 1 cycle, then `gnt_1` for 4 cycles (relock). Pattern repeats.
- Lock release: in LOCK1, drop `lock_1` with `req_1`=1 -> `gnt_1` that cycle, then `gnt_0` next cycle (`ptr`=0).
- Mid-burst reset: assert `reset` in LOCK1 on a read-grant cycle -> `gnt_1` and `rvalid_1` fall immediately, and no `rvalid_1` follows. After release with only `req_0`, `gnt_0`=1.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter (port 0 = cpu, port 1 = debug loader)
// with a bounded lock for burst loading and a one-cycle registered read return.

module mem_arbiter_rsp #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         gnt,
  input  logic         rd,
  input  logic [N-1:0] m_rdata,
  output logic         rvalid,
  output logic [N-1:0] rdata
);
  logic         rvalid_d, rvalid_q;
  logic [N-1:0] rdata_d, rdata_q;

  always_comb begin
    rvalid_d = gnt & rd;
    rdata_d  = rvalid_d ? m_rdata : rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
endmodule

module mem_arbiter #(
  parameter int N       = 64,
  parameter int MAXLOCK = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_0,
  input  logic         lock_0,
  input  logic [1:0]   we_0,
  input  logic         rtype_0,
  input  logic [N-1:0] addr_0,
  input  logic [N-1:0] wdata_0,
  output logic         gnt_0,
  output logic         rvalid_0,
  output logic [N-1:0] rdata_0,
  input  logic         req_1,
  input  logic         lock_1,
  input  logic [1:0]   we_1,
  input  logic         rtype_1,
  input  logic [N-1:0] addr_1,
  input  logic [N-1:0] wdata_1,
  output logic         gnt_1,
  output logic         rvalid_1,
  output logic [N-1:0] rdata_1,
  output logic [1:0]   m_memwrite,
  output logic         m_readtype,
  output logic [N-1:0] m_adr,
  output logic [N-1:0] m_wdata,
  input  logic [N-1:0] m_rdata
);
  localparam int NP = 2;
  localparam int CW = $clog2(MAXLOCK + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAXLOCK);

  typedef enum logic [1:0] {S_IDLE, S_LOCK0, S_LOCK1} st_e;

  logic [NP-1:0]        req, lock, rtype, rd, gnt_arb, gnt, rvalid;
  logic [NP-1:0][1:0]   we;
  logic [NP-1:0][N-1:0] addr, wdata, rdata;

  assign req   = {req_1, req_0};
  assign lock  = {lock_1, lock_0};
  assign rtype = {rtype_1, rtype_0};
  assign we    = {we_1, we_0};
  assign addr  = {addr_1, addr_0};
  assign wdata = {wdata_1, wdata_0};

  st_e           st_q, st_d;
  logic          ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          own, oth, win;

  always_comb begin
    st_d    = st_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_arb = '0;
    own     = (st_q == S_LOCK1);
    oth     = ~own;
    win     = 1'b0;
    if (st_q != S_IDLE && req[own]) begin
      if (cnt_q < MAXC || !req[oth]) begin
        gnt_arb[own] = 1'b1;
        cnt_d        = (cnt_q == MAXC) ? cnt_q : cnt_q + 1'b1;
        if (!lock[own]) begin
          st_d  = S_IDLE;
          cnt_d = '0;
          ptr_d = oth;
        end
      end else begin
        // Lock budget spent while the other port waits: hand it one slot.
        gnt_arb[oth] = 1'b1;
        st_d         = S_IDLE;
        cnt_d        = '0;
        ptr_d        = own;
      end
    end else begin
      // Plain round-robin; also covers a lock owner that stopped requesting.
      st_d  = S_IDLE;
      cnt_d = '0;
      if (req != '0) begin
        win          = (req == 2'b11) ? ptr_q : req[1];
        gnt_arb[win] = 1'b1;
        ptr_d        = ~win;
        if (lock[win]) begin
          st_d  = win ? S_LOCK1 : S_LOCK0;
          cnt_d = CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q  <= S_IDLE;
      ptr_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign gnt = gnt_arb & {NP{~reset}};

  always_comb begin
    m_memwrite = '0;
    m_readtype = 1'b0;
    m_adr      = '0;
    m_wdata    = '0;
    for (int p = 0; p < NP; p++) begin
      if (gnt[p]) begin
        m_memwrite = we[p];
        m_readtype = rtype[p];
        m_adr      = addr[p];
        m_wdata    = wdata[p];
      end
    end
  end

  for (genvar g = 0; g < NP; g++) begin : g_rsp
    assign rd[g] = (we[g] == 2'b00);
    mem_arbiter_rsp #(.N(N)) u_rsp (
      .clk     (clk),
      .reset   (reset),
      .gnt     (gnt[g]),
      .rd      (rd[g]),
      .m_rdata (m_rdata),
      .rvalid  (rvalid[g]),
      .rdata   (rdata[g])
    );
  end

  assign gnt_0    = gnt[0];
  assign gnt_1    = gnt[1];
  assign rvalid_0 = rvalid[0];
  assign rvalid_1 = rvalid[1];
  assign rdata_0  = rdata[0];
  assign rdata_1  = rdata[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural arbitration model.

module tb_mem_arbiter;
  localparam int N       = 64;
  localparam int MAXLOCK = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           req, lock, rtype;
  logic [1:0][1:0]      we;
  logic [1:0][N-1:0]    addr, wdata;
  logic [N-1:0]         m_rdata;
  logic                 gnt_0, gnt_1, rvalid_0, rvalid_1;
  logic [N-1:0]         rdata_0, rdata_1;
  logic [1:0]           m_memwrite;
  logic                 m_readtype;
  logic [N-1:0]         m_adr, m_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: current lock owner (-1 none), grants in this lock, preferred port
  int                owner   = -1;
  int                run     = 0;
  int                rr      = 0;
  int                mdl_win = -1;
  bit [1:0]          e_rv    = '0;
  logic [1:0][N-1:0] e_rd    = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.N(N), .MAXLOCK(MAXLOCK)) dut (
    .clk(clk), .reset(reset),
    .req_0(req[0]), .lock_0(lock[0]), .we_0(we[0]), .rtype_0(rtype[0]),
    .addr_0(addr[0]), .wdata_0(wdata[0]),
    .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
    .req_1(req[1]), .lock_1(lock[1]), .we_1(we[1]), .rtype_1(rtype[1]),
    .addr_1(addr[1]), .wdata_1(wdata[1]),
    .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
    .m_memwrite(m_memwrite), .m_readtype(m_readtype), .m_adr(m_adr),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : model
    int       win;
    bit       handled;
    logic [1:0] eg;
    win     = -1;
    handled = 1'b0;
    if (reset) begin
      owner = -1;
      run   = 0;
      rr    = 0;
      e_rv  = '0;
      e_rd  = '0;
    end else begin
      if (owner >= 0 && req[owner]) begin
        handled = 1'b1;
        if (run < MAXLOCK || !req[1-owner]) begin
          win = owner;
          if (run < MAXLOCK) run++;
          if (!lock[owner]) begin
            rr    = 1 - owner;
            owner = -1;
            run   = 0;
          end
        end else begin
          win   = 1 - owner;
          rr    = owner;
          owner = -1;
          run   = 0;
        end
      end
      if (!handled) begin
        owner = -1;
        run   = 0;
        if (req == 2'b11)  win = rr;
        else if (req[0])   win = 0;
        else if (req[1])   win = 1;
        if (win >= 0) begin
          rr = 1 - win;
          if (lock[win]) begin
            owner = win;
            run   = 1;
          end
        end
      end
    end

    eg = (win < 0) ? 2'b00 : ((win == 0) ? 2'b01 : 2'b10);
    chk("gnt", N'({gnt_1, gnt_0}), N'(eg));
    if (win < 0) begin
      chk("m_memwrite_idle", N'(m_memwrite), '0);
      chk("m_readtype_idle", N'(m_readtype), '0);
      chk("m_adr_idle", m_adr, '0);
      chk("m_wdata_idle", m_wdata, '0);
    end else begin
      chk("m_memwrite", N'(m_memwrite), N'(we[win]));
      chk("m_readtype", N'(m_readtype), N'(rtype[win]));
      chk("m_adr", m_adr, addr[win]);
      chk("m_wdata", m_wdata, wdata[win]);
    end
    chk("rvalid", N'({rvalid_1, rvalid_0}), N'(e_rv));
    chk("rdata_0", rdata_0, e_rd[0]);
    chk("rdata_1", rdata_1, e_rd[1]);

    if (!reset) begin
      for (int p = 0; p < 2; p++) begin
        e_rv[p] = (win == p) && (we[p] == 2'b00);
        if (e_rv[p]) e_rd[p] = m_rdata;
      end
    end
    mdl_win = win;
  end

  initial begin
    logic [1:0] eg, prev;
    reset   = 1'b1;
    req     = 2'b11;
    lock    = 2'b00;
    rtype   = 2'b00;
    we      = {2'b00, 2'b11};
    addr    = '0;
    wdata   = '0;
    m_rdata = '0;

    // reset held with both requesting
    smp(); smp();
    chk("rst_gnt", N'({gnt_1, gnt_0}), N'(2'b00));
    chk("rst_memwrite", N'(m_memwrite), N'(2'b00));
    chk("rst_rvalid", N'({rvalid_1, rvalid_0}), N'(2'b00));
    chk("rst_rdata_0", rdata_0, '0);
    chk("rst_rdata_1", rdata_1, '0);
    nxt();
    reset = 1'b0;
    smp();
    chk("post_rst_gnt", N'({gnt_1, gnt_0}), N'(2'b01));
    chk("post_rst_memwrite", N'(m_memwrite), N'(2'b11));

    // single read on port 0
    nxt();
    req     = 2'b01;
    we      = '0;
    addr[0] = 64'h40;
    m_rdata = 64'hDEAD_BEEF;
    smp();
    chk("rd_gnt", N'({gnt_1, gnt_0}), N'(2'b01));
    chk("rd_adr", m_adr, 64'h40);
    nxt();
    req     = 2'b00;
    m_rdata = 64'h1234;
    smp();
    chk("rd_rvalid", N'(rvalid_0), N'(1'b1));
    chk("rd_rdata", rdata_0, 64'hDEAD_BEEF);
    nxt();
    smp();
    chk("rd_rvalid_pulse", N'(rvalid_0), N'(1'b0));
    chk("rd_rdata_hold", rdata_0, 64'hDEAD_BEEF);

    // fairness: continuous reads from both, pointer currently at port 1
    nxt();
    req     = 2'b11;
    addr[0] = 64'h100;
    addr[1] = 64'h200;
    prev    = 2'b00;
    for (int k = 0; k < 8; k++) begin
      m_rdata = {$urandom, $urandom};
      smp();
      eg = (k % 2 == 0) ? 2'b10 : 2'b01;
      chk("fair_gnt", N'({gnt_1, gnt_0}), N'(eg));
      chk("fair_rvalid", N'({rvalid_1, rvalid_0}), N'(prev));
      prev = eg;
      nxt();
    end

    // forced release: port 1 locked writes vs port 0 reads
    req   = 2'b11;
    lock  = 2'b10;
    we[1] = 2'b01;
    for (int i = 0; i < 15; i++) begin
      smp();
      eg = (i % 5 == 4) ? 2'b01 : 2'b10;
      chk("force_gnt", N'({gnt_1, gnt_0}), N'(eg));
      if (i % 5 != 4) chk("force_memwrite", N'(m_memwrite), N'(2'b01));
      nxt();
    end

    // lock release with request still high
    req  = 2'b10;
    lock = 2'b10;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        lock = 2'b00;
        req  = 2'b11;
      end
      smp();
      eg = (i < 3) ? 2'b10 : 2'b01;
      chk("release_gnt", N'({gnt_1, gnt_0}), N'(eg));
      nxt();
    end

    // reset in the middle of a locked read burst
    req  = 2'b10;
    lock = 2'b10;
    we   = '0;
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("burst_gnt", N'({gnt_1, gnt_0}), N'(2'b10));
      if (i == 1) chk("burst_rvalid", N'(rvalid_1), N'(1'b1));
      nxt();
    end
    #2;
    chk("pre_rst_gnt", N'({gnt_1, gnt_0}), N'(2'b10));
    chk("pre_rst_rvalid", N'(rvalid_1), N'(1'b1));
    reset = 1'b1;
    #1;
    chk("mid_rst_gnt", N'({gnt_1, gnt_0}), N'(2'b00));
    chk("mid_rst_rvalid", N'(rvalid_1), N'(1'b0));
    smp();
    nxt();
    req  = 2'b01;
    lock = 2'b00;
    smp();
    chk("held_rst_rvalid", N'(rvalid_1), N'(1'b0));
    nxt();
    reset = 1'b0;
    smp();
    chk("after_rst_gnt", N'({gnt_1, gnt_0}), N'(2'b01));
    chk("after_rst_rvalid", N'(rvalid_1), N'(1'b0));
    nxt();

    // randomized traffic; a waiting requester keeps its request and payload
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!(req[p] && mdl_win != p && !reset)) begin
          req[p]   = ($urandom_range(0, 99) < 65);
          we[p]    = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(1, 3));
          rtype[p] = 1'($urandom_range(0, 1));
          addr[p]  = {$urandom, $urandom};
          wdata[p] = {$urandom, $urandom};
        end
        lock[p] = ($urandom_range(0, 2) != 0);
      end
      m_rdata = {$urandom, $urandom};
      reset   = ($urandom_range(0, 249) == 0);
      smp();
      nxt();
    end

    reset = 1'b0;
    req   = 2'b00;
    smp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
